// File: rtl/serdes_defs.sv
// Shared definitions for the serializer slice: FSM encodings, default word
// width and a counter-width helper.
package serdes_defs;

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_SHIFT = 2'd1;
    localparam logic [1:0] S_DONE  = 2'd2;

    localparam int DEFAULT_WIDTH = 8;

    // Counter width for a count range 0..n-1; never narrower than one bit.
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/piso_serializer_8bit_tick.sv
// Bit-period timer: counts DIV clocks while enabled and flags the last clock of
// each serial bit period. A synchronous clear restarts the period.
module bit_tick_gen
    import serdes_defs::*;
#(
    parameter int DIV = 1
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic en,
    output logic tick
);

    localparam int DCW = cnt_width(DIV);
    localparam logic [DCW-1:0] DIV_LAST = DCW'(DIV - 1);

    logic [DCW-1:0] div_cnt_r;

    assign tick = en && (div_cnt_r == DIV_LAST);

    // Period counter: wraps at DIV-1, so with DIV=1 it simply stays at zero.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_cnt_r <= {DCW{1'b0}};
        end else if (clr) begin
            div_cnt_r <= {DCW{1'b0}};
        end else if (en) begin
            if (div_cnt_r == DIV_LAST) begin
                div_cnt_r <= {DCW{1'b0}};
            end else begin
                div_cnt_r <= div_cnt_r + DCW'(1);
            end
        end else begin
            div_cnt_r <= div_cnt_r;
        end
    end

endmodule

// File: rtl/piso_serializer_8bit.sv
// Parallel-in/serial-out stage: accepts a word on load&&ready, shifts it out
// one bit per DIV clocks and pulses done for one cycle after the last bit.
module piso_serializer_8bit
    import serdes_defs::*;
#(
    parameter int WIDTH     = DEFAULT_WIDTH,
    parameter int DIV       = 1,
    parameter bit MSB_FIRST = 1'b1
) (
    input  logic             CLK,
    input  logic             RST,
    input  logic             load,
    input  logic [WIDTH-1:0] data_in,
    output logic             ready,
    output logic             ser_out,
    output logic             ser_en,
    output logic             done
);

    localparam int BCW = $clog2(WIDTH);
    localparam logic [BCW-1:0] LAST_BIT = BCW'(WIDTH - 1);

    logic [1:0]       state_r;
    logic [1:0]       state_nxt_s;
    logic [WIDTH-1:0] shreg_r;
    logic [WIDTH-1:0] shreg_nxt_s;
    logic [BCW-1:0]   bit_cnt_r;
    logic [BCW-1:0]   bit_cnt_nxt_s;
    logic             accept_s;
    logic             tick_s;
    logic             ready_r;
    logic             ser_out_r;
    logic             ser_en_r;
    logic             done_r;

    function automatic logic out_bit(input logic [WIDTH-1:0] w);
        if (MSB_FIRST) begin
            return w[WIDTH-1];
        end else begin
            return w[0];
        end
    endfunction

    // Vacated positions fill with zero in both directions.
    function automatic logic [WIDTH-1:0] shift_word(input logic [WIDTH-1:0] w);
        if (MSB_FIRST) begin
            return {w[WIDTH-2:0], 1'b0};
        end else begin
            return {1'b0, w[WIDTH-1:1]};
        end
    endfunction

    bit_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk   (CLK),
        .rst_n (RST),
        .clr   (accept_s),
        .en    (state_r == S_SHIFT),
        .tick  (tick_s)
    );

    // Next-state logic for the FSM, shift register and bit counter.
    always_comb begin
        state_nxt_s   = state_r;
        shreg_nxt_s   = shreg_r;
        bit_cnt_nxt_s = bit_cnt_r;
        accept_s      = 1'b0;
        case (state_r)
            S_IDLE, S_DONE: begin
                if (load) begin
                    accept_s      = 1'b1;
                    shreg_nxt_s   = data_in;
                    bit_cnt_nxt_s = {BCW{1'b0}};
                    state_nxt_s   = S_SHIFT;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_SHIFT: begin
                if (tick_s) begin
                    shreg_nxt_s = shift_word(shreg_r);
                    if (bit_cnt_r == LAST_BIT) begin
                        bit_cnt_nxt_s = {BCW{1'b0}};
                        state_nxt_s   = S_DONE;
                    end else begin
                        bit_cnt_nxt_s = bit_cnt_r + BCW'(1);
                    end
                end else begin
                    state_nxt_s = S_SHIFT;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
            end
        endcase
    end

    // State registers; outputs are decoded from the next state so they are registered.
    always_ff @(posedge CLK or negedge RST) begin
        if (!RST) begin
            state_r   <= S_IDLE;
            shreg_r   <= {WIDTH{1'b0}};
            bit_cnt_r <= {BCW{1'b0}};
            ready_r   <= 1'b1;
            ser_out_r <= 1'b0;
            ser_en_r  <= 1'b0;
            done_r    <= 1'b0;
        end else begin
            state_r   <= state_nxt_s;
            shreg_r   <= shreg_nxt_s;
            bit_cnt_r <= bit_cnt_nxt_s;
            ready_r   <= (state_nxt_s != S_SHIFT);
            ser_en_r  <= (state_nxt_s == S_SHIFT);
            ser_out_r <= (state_nxt_s == S_SHIFT) ? out_bit(shreg_nxt_s) : 1'b0;
            done_r    <= (state_nxt_s == S_DONE);
        end
    end

    assign ready   = ready_r;
    assign ser_out = ser_out_r;
    assign ser_en  = ser_en_r;
    assign done    = done_r;

endmodule

// File: tb/tb_piso_serializer_8bit.sv
// Scoreboard bench for piso_serializer_8bit: lane 0 runs DIV=1/MSB-first,
// lane 1 runs DIV=4/LSB-first; a deserializing monitor checks every frame.
module tb_piso_serializer_8bit;

    logic       CLK;
    logic       RST;
    logic       load_a    [2];
    logic [7:0] data_a    [2];
    logic       ready_a   [2];
    logic       ser_out_a [2];
    logic       ser_en_a  [2];
    logic       done_a    [2];

    int checks = 0;
    int errors = 0;

    // Reference model state: cycles of frame left, expected done, counters.
    int   frame_left [2];
    logic done_exp   [2];
    int   acc_cnt    [2];
    int   aborted    [2];
    int   done_cnt   [2];
    logic [7:0] q0 [$];
    logic [7:0] q1 [$];

    // Monitor deserializer state.
    int         pos   [2];
    int         nbits [2];
    logic [7:0] col_w [2];
    logic       held  [2];

    piso_serializer_8bit #(.WIDTH(8), .DIV(1), .MSB_FIRST(1'b1)) dut0 (
        .CLK(CLK), .RST(RST), .load(load_a[0]), .data_in(data_a[0]),
        .ready(ready_a[0]), .ser_out(ser_out_a[0]), .ser_en(ser_en_a[0]), .done(done_a[0]));

    piso_serializer_8bit #(.WIDTH(8), .DIV(4), .MSB_FIRST(1'b0)) dut1 (
        .CLK(CLK), .RST(RST), .load(load_a[1]), .data_in(data_a[1]),
        .ready(ready_a[1]), .ser_out(ser_out_a[1]), .ser_en(ser_en_a[1]), .done(done_a[1]));

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    function automatic int div_of(input int l);
        return (l == 0) ? 1 : 4;
    endfunction

    function automatic bit msb_of(input int l);
        return (l == 0);
    endfunction

    task automatic check(input string name, input int l, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s lane%0d t=%0t: got %0h expected %0h", name, l, $time, act, exp);
        end
    endtask

    // Reference model: a frame lasts 8*DIV cycles from the accept edge, then one done cycle.
    always @(posedge CLK or negedge RST) begin
        if (!RST) begin
            for (int l = 0; l < 2; l++) begin
                if (frame_left[l] > 0) aborted[l] <= aborted[l] + 1;
                frame_left[l] <= 0;
                done_exp[l]   <= 1'b0;
            end
            q0.delete();
            q1.delete();
        end else begin
            for (int l = 0; l < 2; l++) begin
                if (load_a[l] && frame_left[l] == 0) begin
                    frame_left[l] <= 8 * div_of(l);
                    done_exp[l]   <= 1'b0;
                    acc_cnt[l]    <= acc_cnt[l] + 1;
                    if (l == 0) q0.push_back(data_a[l]);
                    else        q1.push_back(data_a[l]);
                end else if (frame_left[l] > 0) begin
                    frame_left[l] <= frame_left[l] - 1;
                    done_exp[l]   <= (frame_left[l] == 1);
                end else begin
                    done_exp[l] <= 1'b0;
                end
            end
        end
    end

    // Monitor: per-cycle handshake checks plus deserialization compared on done.
    always @(negedge CLK) begin
        if (!RST) begin
            for (int l = 0; l < 2; l++) begin
                check("rst_ready", l, int'(ready_a[l]), 1);
                check("rst_ser_en", l, int'(ser_en_a[l]), 0);
                check("rst_ser_out", l, int'(ser_out_a[l]), 0);
                check("rst_done", l, int'(done_a[l]), 0);
                pos[l]   <= 0;
                nbits[l] <= 0;
                col_w[l] <= 8'h00;
            end
        end else begin
            for (int l = 0; l < 2; l++) begin
                logic [7:0] nw;
                logic [7:0] expw;
                check("ready", l, int'(ready_a[l]), int'(frame_left[l] == 0));
                check("ser_en", l, int'(ser_en_a[l]), int'(frame_left[l] > 0));
                check("done", l, int'(done_a[l]), int'(done_exp[l]));
                if (ser_en_a[l]) begin
                    if (pos[l] % div_of(l) == 0) begin
                        nw = msb_of(l) ? {col_w[l][6:0], ser_out_a[l]} : {ser_out_a[l], col_w[l][7:1]};
                        col_w[l] <= nw;
                        nbits[l] <= nbits[l] + 1;
                        held[l]  <= ser_out_a[l];
                    end else begin
                        check("bit_hold", l, int'(ser_out_a[l]), int'(held[l]));
                    end
                    pos[l] <= pos[l] + 1;
                end else begin
                    check("idle_out", l, int'(ser_out_a[l]), 0);
                    pos[l] <= 0;
                end
                if (done_a[l]) begin
                    done_cnt[l] <= done_cnt[l] + 1;
                    if ((l == 0 && q0.size() == 0) || (l == 1 && q1.size() == 0)) begin
                        checks++;
                        errors++;
                        $display("FAIL word lane%0d t=%0t: done with no pending word", l, $time);
                    end else begin
                        expw = (l == 0) ? q0.pop_front() : q1.pop_front();
                        check("nbits", l, nbits[l], 8);
                        check("word", l, int'(col_w[l]), int'(expw));
                    end
                    col_w[l] <= 8'h00;
                    nbits[l] <= 0;
                end
            end
        end
    end

    task automatic send(input int l, input logic [7:0] w);
        int n;
        bit got;
        n   = acc_cnt[l];
        got = 1'b0;
        load_a[l] = 1'b1;
        data_a[l] = w;
        for (int c = 0; c < 200 && !got; c++) begin
            @(posedge CLK);
            #1;
            if (acc_cnt[l] != n) got = 1'b1;
        end
        load_a[l] = 1'b0;
        data_a[l] = 8'($urandom);
        if (!got) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout lane%0d: word %0h never accepted", l, w);
        end
    endtask

    task automatic wait_idle(input int l);
        bit idle;
        idle = 1'b0;
        for (int c = 0; c < 200 && !idle; c++) begin
            @(posedge CLK);
            #1;
            if (frame_left[l] == 0 && !done_exp[l]) idle = 1'b1;
        end
        if (!idle) begin
            checks++;
            errors++;
            $display("FAIL idle_timeout lane%0d", l);
        end
    endtask

    initial begin
        RST = 1'b0;
        for (int l = 0; l < 2; l++) begin
            load_a[l] = 1'b0;
            data_a[l] = 8'h00;
        end
        repeat (3) @(posedge CLK);
        #1 RST = 1'b1;
        @(posedge CLK);
        #1;

        // Single frame, then ignored loads while busy.
        send(0, 8'hA5);
        repeat (2) begin @(posedge CLK); #1; end
        load_a[0] = 1'b1;
        data_a[0] = 8'h00;
        repeat (3) begin @(posedge CLK); #1; end
        load_a[0] = 1'b0;
        wait_idle(0);

        // Back-to-back: load held high across the done cycle.
        load_a[0] = 1'b1;
        data_a[0] = 8'hFF;
        send(0, 8'hFF);
        send(0, 8'h3C);
        wait_idle(0);

        // Reset mid-frame after the third bit, then a clean frame.
        send(0, 8'h55);
        repeat (3) begin @(posedge CLK); #1; end
        RST = 1'b0;
        #1;
        check("abort_ser_en", 0, int'(ser_en_a[0]), 0);
        check("abort_ser_out", 0, int'(ser_out_a[0]), 0);
        check("abort_ready", 0, int'(ready_a[0]), 1);
        check("abort_done", 0, int'(done_a[0]), 0);
        @(posedge CLK);
        #1 RST = 1'b1;
        @(posedge CLK);
        #1;
        send(0, 8'hC3);
        wait_idle(0);

        // Slow LSB-first lane.
        send(1, 8'h01);
        wait_idle(1);

        // Randomised traffic on both lanes.
        fork
            begin
                for (int i = 0; i < 100; i++) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge CLK); #1; end
                    send(0, 8'($urandom));
                end
            end
            begin
                for (int j = 0; j < 100; j++) begin
                    repeat ($urandom_range(0, 3)) begin @(posedge CLK); #1; end
                    send(1, 8'($urandom));
                end
            end
        join
        wait_idle(0);
        wait_idle(1);
        repeat (2) @(posedge CLK);
        #1;

        for (int l = 0; l < 2; l++) begin
            check("done_count", l, done_cnt[l], acc_cnt[l] - aborted[l]);
        end
        check("pending_q0", 0, q0.size(), 0);
        check("pending_q1", 1, q1.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
